fifo_ctrl: RTL
==============

Name: fifo_ctrl

Overview:
Single-clock FIFO controller that sits directly upstream of the dual-port FIFO memory (dual_mm_port) and drives it. It accepts push/pop requests, gates them against full/empty, and produces the memory write/read enables and addresses. It also maintains the occupancy count, full/empty/almost flags, a read-data-valid strobe aligned to the memory's registered output, and sticky overflow/underflow error flags. The memory's wr_clk and rd_clk are both tied to clk.

Parameters:
DEPTH, 8, number of memory entries; must be a power of 2, minimum 2
ADDR_W, 3, address width; must equal log2(DEPTH)
AFULL_TH, 6, almost_full_o asserts when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty_o asserts when count <= AEMPTY_TH

Ports:
clk  input  1  single clock; rising edge; drives controller and both memory ports
rst_n  input  1  reset, asynchronous assert, active-low
push_i  input  1  write request; data is presented to the memory by the upstream source
pop_i  input  1  read request
clr_err_i  input  1  clears overflow_o and underflow_o
wr_en_o  output  1  memory write enable (accepted push)
wr_addr_o  output  ADDR_W  memory write address
rd_en_o  output  1  memory read enable (accepted pop)
rd_addr_o  output  ADDR_W  memory read address
rd_valid_o  output  1  memory data_o valid this cycle
full_o  output  1  count == DEPTH
empty_o  output  1  count == 0
almost_full_o  output  1  count >= AFULL_TH
almost_empty_o  output  1  count <= AEMPTY_TH
count_o  output  ADDR_W+1  occupancy, 0..DEPTH
overflow_o  output  1  sticky: push attempted while full
underflow_o  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, rd_valid_o=0, overflow_o=0, underflow_o=0. Memory contents are not cleared.
- Pointers are ADDR_W+1 bits wide; the MSB is the wrap bit. wr_addr_o and rd_addr_o are the low ADDR_W bits of the respective pointer. Address DEPTH-1 wraps to 0.
- Accept conditions are combinational and use registered flags only:
  - push_ok = push_i & ~full_o; wr_en_o = push_ok.
  - pop_ok = pop_i & ~empty_o; rd_en_o = pop_ok.
- Full has strict priority: a push while full_o=1 is rejected even if a pop is accepted in the same cycle.
- Empty has strict priority: a pop while empty_o=1 is rejected even if a push is accepted in the same cycle. There is no write-through.
- On each rising edge:
  - push_ok increments wr_ptr; pop_ok increments rd_ptr.
  - count_o: +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither are accepted.
- Flags are registered and derived from the next count value, so they are valid in the same cycle as the updated count_o. There is no combinational path from push_i/pop_i to any flag.
- Invariant: count_o == wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)). full_o is equivalent to pointers equal except the MSB; empty_o is equivalent to pointers fully equal.
- rd_valid_o is registered: rd_valid_o = pop_ok delayed one cycle, matching the memory's one-cycle registered read latency.
- overflow_o is set on push_i & full_o; underflow_o is set on pop_i & empty_o. Both stay set until clr_err_i. If a set and a clear occur in the same cycle, the set wins.
- Latency: push-to-empty_o deassert is 1 cycle; pop-to-data is 1 cycle.
- Reset asserted mid-operation: all state returns to reset values immediately. A pending rd_valid_o is dropped.

Test Plan:
- Reset: hold rst_n low, toggle push_i/pop_i -> all outputs at reset values; empty_o=1, count_o=0, no enables registered after release.
- Fill: 8 consecutive pushes -> wr_addr_o steps 0..7. almost_full_o rises at count 6. full_o=1 at count 8. 9th push -> wr_en_o=0, overflow_o=1, count stays 8. clr_err_i -> overflow_o=0.
- Drain: from full, 8 pops -> rd_addr_o steps 0..7, rd_valid_o one cycle after each rd_en_o. almost_empty_o rises at count 2. empty_o=1 at 0. Extra pop -> underflow_o=1.
- Simultaneous: at count 4, push_i=pop_i=1 for 5 cycles -> both enables high each cycle, count stays 4. At count 8 with both -> only rd_en_o, count 7. At count 0 with both -> only wr_en_o, count 1.
- Wrap: 12 interleaved push/pop pairs from count 3 -> addresses wrap 7->0, flags and count stay consistent, data read in order through the memory.
- Mid-op reset: assert rst_n low at count 5, one cycle after a pop -> rd_valid_o=0 immediately, count_o=0, empty_o=1; normal operation resumes after release.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: gates push/pop against registered full/empty,
// drives the dual-port memory enables/addresses, and tracks occupancy, flags and sticky errors.
module fifo_ctrl #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clr_err_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AE_TH = (ADDR_W+1)'(AEMPTY_TH);

  generate
    if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : g_bad_depth
      $error("fifo_ctrl: DEPTH must be a power of 2 >= 2 and equal 2**ADDR_W");
    end
  endgenerate

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] count_q, count_nxt;
  logic            push_ok, pop_ok;

  // Accept decisions look only at registered flags: no push_i/pop_i -> flag path.
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i  & ~empty_o;
  assign wr_en_o   = push_ok;
  assign rd_en_o   = pop_ok;
  assign wr_addr_o = wr_ptr[ADDR_W-1:0];
  assign rd_addr_o = rd_ptr[ADDR_W-1:0];
  assign count_o   = count_q;

  always_comb begin
    count_nxt = count_q;
    if (push_ok && !pop_ok)      count_nxt = count_q + ONE;
    else if (pop_ok && !push_ok) count_nxt = count_q - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + ONE;
      count_q <= count_nxt;
    end
  end

  // Flags come from the next count so they line up with the updated count_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
    end else begin
      full_o         <= (count_nxt == FULL);
      empty_o        <= (count_nxt == '0);
      almost_full_o  <= (count_nxt >= AF_TH);
      almost_empty_o <= (count_nxt <= AE_TH);
    end
  end

  // One-cycle read valid matches the memory's registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_o <= 1'b0;
    else        rd_valid_o <= pop_ok;
  end

  // Sticky errors; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= (push_i & full_o)  | (overflow_o  & ~clr_err_i);
      underflow_o <= (pop_i  & empty_o) | (underflow_o & ~clr_err_i);
    end
  end

endmodule
